// File: rtl/l_buffer_loader.sv
// l_buffer_loader: streams clause words then pointer words for each engine
// into the latency buffer, one engine after another, with load strobes.
// Ports: clock/reset (async, active-high); start pulse; clause_src and
// ptr_src valid/ready streams; clause_out/ptr_out data with load strobes
// load_clause_out/load_ptr_out/load_change_engine_out; engine_idx; busy;
// done pulse; ovf_err (sticky clause overflow).
// Build option: LOADER_OVF_CHECK_EN enables clause-queue overflow detection.

package l_buffer_loader_pkg;
    typedef logic [31:0] node_t;
    typedef logic [15:0] ptr_t;
endpackage

module l_buffer_loader
    import l_buffer_loader_pkg::*;
#(
    parameter int NUM_ENGINE  = 2,
    parameter int LIT_IDX_MAX = 4,
    parameter int CLQ_DEPTH   = 64,
    localparam int EW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  node_t         clause_src,
    input  logic          clause_src_valid,
    input  logic          clause_src_last,
    output logic          clause_src_ready,
    input  ptr_t          ptr_src,
    input  logic          ptr_src_valid,
    output logic          ptr_src_ready,
    output node_t         clause_out,
    output ptr_t          ptr_out,
    output logic          load_clause_out,
    output logic          load_ptr_out,
    output logic          load_change_engine_out,
    output logic [EW-1:0] engine_idx,
    output logic          busy,
    output logic          done,
    output logic          ovf_err
);

    localparam int CW = (CLQ_DEPTH > 1) ? $clog2(CLQ_DEPTH) : 1;
    localparam int PN = 2 * LIT_IDX_MAX;
    localparam int PW = (PN > 1) ? $clog2(PN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLAUSE,
        S_PTR,
        S_SWITCH,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_clause_cnt;
    logic [PW-1:0] r_ptr_cnt;
    logic [EW-1:0] r_engine_idx;
    node_t         r_clause_out;
    ptr_t          r_ptr_out;
    logic          r_load_clause;
    logic          r_load_ptr;
    logic          r_load_chg;
    logic          r_done;

    logic w_cl_xfer;
    logic w_pt_xfer;
    logic w_pt_wrap;
    logic w_last_eng;
    logic w_cl_full;
    logic w_ovf_hit;

    // Ready is purely a function of state, so a transfer is just valid
    // while in the owning state.
    assign w_cl_xfer  = (r_state == S_CLAUSE) && clause_src_valid;
    assign w_pt_xfer  = (r_state == S_PTR) && ptr_src_valid;
    assign w_pt_wrap  = (r_ptr_cnt == PW'(PN - 1));
    assign w_last_eng = (r_engine_idx == EW'(NUM_ENGINE - 1));
    assign w_cl_full  = (r_clause_cnt == CW'(CLQ_DEPTH - 1));

`ifdef LOADER_OVF_CHECK_EN
    logic r_ovf;

    // A full queue without a last marker is closed out as if last.
    assign w_ovf_hit = w_cl_xfer && w_cl_full && !clause_src_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_hit) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf_err = r_ovf;
`else
    assign w_ovf_hit = 1'b0;
    assign ovf_err   = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        clause_src_ready = 1'b0;
        ptr_src_ready    = 1'b0;
        busy             = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_CLAUSE;
                end
            end
            S_CLAUSE: begin
                clause_src_ready = 1'b1;
                if (w_cl_xfer && (clause_src_last || w_ovf_hit)) begin
                    w_next = S_PTR;
                end
            end
            S_PTR: begin
                ptr_src_ready = 1'b1;
                if (w_pt_xfer && w_pt_wrap) begin
                    w_next = w_last_eng ? S_DONE : S_SWITCH;
                end
            end
            S_SWITCH: w_next = S_CLAUSE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Strobes are registered one cycle behind the event that causes them;
    // the states are mutually exclusive, so at most one strobe fires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clause_cnt  <= '0;
            r_ptr_cnt     <= '0;
            r_engine_idx  <= '0;
            r_clause_out  <= '0;
            r_ptr_out     <= '0;
            r_load_clause <= 1'b0;
            r_load_ptr    <= 1'b0;
            r_load_chg    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_load_clause <= w_cl_xfer;
            r_load_ptr    <= w_pt_xfer;
            r_load_chg    <= (r_state == S_SWITCH);
            r_done        <= (r_state == S_DONE);
            if (w_cl_xfer) begin
                r_clause_out <= clause_src;
                r_clause_cnt <= w_cl_full ? '0 : r_clause_cnt + CW'(1);
            end
            if (w_pt_xfer) begin
                r_ptr_out <= ptr_src;
                r_ptr_cnt <= w_pt_wrap ? '0 : r_ptr_cnt + PW'(1);
            end
            if (r_state == S_IDLE && start) begin
                r_engine_idx <= '0;
                r_clause_cnt <= '0;
                r_ptr_cnt    <= '0;
            end
            if (r_state == S_SWITCH) begin
                r_engine_idx <= r_engine_idx + EW'(1);
                r_clause_cnt <= '0;
            end
        end
    end

    assign clause_out             = r_clause_out;
    assign ptr_out                = r_ptr_out;
    assign load_clause_out        = r_load_clause;
    assign load_ptr_out           = r_load_ptr;
    assign load_change_engine_out = r_load_chg;
    assign done                   = r_done;
    assign engine_idx             = r_engine_idx;

endmodule

// File: doc/l_buffer_loader.md
L_BUFFER_LOADER -- requirements
Module: l_buffer_loader

Interface
REQ-001 Parameter NUM_ENGINE, default 2, number of engines fed in sequence.
REQ-002 Parameter LIT_IDX_MAX, default 4; each engine's pointer group is 2*LIT_IDX_MAX words.
REQ-003 Parameter CLQ_DEPTH, default 64, maximum clauses per engine.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; begins a load sequence.
REQ-007 clause_src  in  $bits(node_t)  clause word from the preprocess store.
REQ-008 clause_src_valid / clause_src_last  in  1 / 1  clause word valid / last clause for current engine.
REQ-009 clause_src_ready  out  1  clause word accepted this cycle.
REQ-010 ptr_src  in  $bits(ptr_t)  pointer word; ptr_src_valid in 1; ptr_src_ready out 1.
REQ-011 clause_out  out  $bits(node_t); ptr_out  out  $bits(ptr_t)  data to the latency buffer.
REQ-012 load_clause_out / load_ptr_out / load_change_engine_out  out  1 each  load strobes to the latency buffer.
REQ-013 engine_idx  out  $clog2(NUM_ENGINE)  engine currently being loaded.
REQ-014 busy  out  1; done  out  1  one-cycle completion pulse; ovf_err  out  1  sticky clause-overflow flag.

Function
REQ-015 States: IDLE, CLAUSE, PTR, SWITCH, DONE.
REQ-016 IDLE: start=1 -> CLAUSE, engine_idx=0, clause/ptr counters=0; start ignored in every other state.
REQ-017 CLAUSE: clause_src_ready=1; a transfer (valid&ready) registers clause_src into clause_out and asserts load_clause_out the next cycle; clause counter increments.
REQ-018 CLAUSE: transfer with clause_src_last=1 -> PTR.
REQ-019 PTR: ptr_src_ready=1; a transfer registers ptr_src into ptr_out and asserts load_ptr_out the next cycle; ptr counter increments.
REQ-020 PTR: transfer when ptr counter == 2*LIT_IDX_MAX-1 -> counter 0; -> DONE if engine_idx==NUM_ENGINE-1, else SWITCH.
REQ-021 SWITCH: lasts exactly one cycle; load_change_engine_out=1 the next cycle; engine_idx increments, clause counter cleared; -> CLAUSE.
REQ-022 DONE: done=1 the next cycle for one cycle; -> IDLE.
REQ-023 No two load strobes are asserted in the same cycle; each strobe is a single-cycle pulse per transfer.
REQ-024 Both ready outputs are 0 outside their own state; clause_src_ready=0 in PTR, ptr_src_ready=0 in CLAUSE.
REQ-025 Valid low in CLAUSE/PTR: the state holds, no strobe, counters hold (stall of arbitrary length).
REQ-026 busy=1 in every state except IDLE.
REQ-027 clause_out / ptr_out hold their last value when their strobe is low.

Reset
REQ-028 reset=1 asynchronously forces IDLE, all counters and engine_idx to 0, all strobes, done, busy, ovf_err, clause_out, ptr_out to 0, including mid-sequence.
REQ-029 First start honoured on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro LOADER_OVF_CHECK_EN defined: in CLAUSE, a transfer when the clause counter == CLQ_DEPTH-1 without clause_src_last sets ovf_err (sticky until reset) and forces -> PTR as if last.
REQ-031 Macro LOADER_OVF_CHECK_EN undefined: ovf_err is tied 0; only clause_src_last leaves CLAUSE; the clause counter wraps modulo CLQ_DEPTH.

Verification
REQ-032 start, engine0 3 clauses (last on 3rd), 8 ptrs, engine1 2 clauses, 8 ptrs, all valid -> 3 load_clause, 8 load_ptr, 1 load_change_engine, 2 load_clause, 8 load_ptr, done pulse; engine_idx 0 then 1.
REQ-033 clause_src_valid toggled 1,0,0,1 during CLAUSE -> exactly 2 load_clause_out pulses, clause_out values in order, no strobe during gaps.
REQ-034 reset asserted after 5th ptr of engine0 -> strobes/busy 0 immediately; new start restarts at engine_idx=0 with ptr counter 0.
REQ-035 start asserted while busy -> no effect; sequence completes identically to REQ-032.
REQ-036 LOADER_OVF_CHECK_EN defined, CLQ_DEPTH=64, 64 clauses without last -> ovf_err=1 after 64th, state PTR; undefined -> ovf_err stays 0, 65th clause accepted.
